unified_mem_responder: RTL and testbench
========================================

// Module: unified_mem_responder
// PURPOSE
//  Memory-side responder for the CPU's unified address path. The core's address mux
//  selects PC or ALU result as the initiator address; this block accepts that request.
//  It executes a byte/half/word load or store against a single-port word array.
//  It returns read data after a programmable number of wait states.
//  It sits between the datapath's address/data mux outputs and the writeback mux input.
// PARAMETERS
//  ADDR_W       32    request address width (byte address)
//  DEPTH        1024  words of storage; must be a power of two
//  WAIT_STATES  2     extra cycles between acceptance and response (0..15)
// PORTS
//  clk          in   1       single clock; all state updates on rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  req_valid    in   1       initiator presents a request
//  req_ready    out  1       responder can accept; high only in IDLE
//  req_we       in   1       1 = store, 0 = load
//  req_addr     in   ADDR_W  byte address
//  req_size     in   2       00 byte, 01 half, 10 word, 11 treated as word
//  req_unsigned in   1       loads: 1 = zero-extend, 0 = sign-extend
//  req_wdata    in   32      store data, right-aligned (bits [7:0] for byte)
//  rsp_valid    out  1       response available; held until rsp_ready
//  rsp_ready    in   1       initiator consumes response
//  rsp_rdata    out  32      extended load data; 0 for stores
//  rsp_err      out  1       misalignment error; constant 0 unless MEM_MISALIGN_TRAP_EN
// BEHAVIOUR
//  Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, counter=0.
//   req_ready rises in the first cycle after reset deasserts.
//   Storage contents are not reset.
//  State machine:
//   IDLE -> WAIT on accept (req_valid & req_ready); fields latched; counter=WAIT_STATES.
//   IDLE -> RESP directly when WAIT_STATES=0.
//   WAIT: decrement counter each cycle; on counter==1 go to RESP.
//   RESP: rsp_valid=1, rsp_rdata and rsp_err stable. On rsp_ready go to IDLE.
//  Latency: rsp_valid asserts exactly WAIT_STATES+1 cycles after the accept edge.
//  Throughput: at most one transaction per WAIT_STATES+2 cycles.
//   A new request is accepted no earlier than the cycle after the response handshake.
//   req_valid & req_ready and rsp_valid never overlap.
//  Array access:
//   Word index = req_addr[2+log2(DEPTH)-1:2]; upper address bits ignored (wraps modulo DEPTH).
//   Store commits on the WAIT->RESP (or IDLE->RESP) transition, using a lane mask from
//    size and addr[1:0]; unselected bytes are preserved.
//   Load reads the word at that same transition. The selected lane is shifted to bit 0
//    and sign- or zero-extended per req_unsigned; a word is passed through.
//   Store response: rsp_rdata=0. A read after a write to the same address sees the new data.
//  Misalignment (half with addr[0]=1; word with addr[1:0]!=0) is handled as below
//   when the macro is undefined: low bits are forced aligned (half uses addr[1],
//   word uses lane 0) and the access proceeds.
//  Reset mid-transaction: returns to IDLE immediately. A pending store that has not
//   reached its commit edge is dropped, and no response is produced.
//  Request inputs are ignored outside IDLE.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined:
//   A misaligned request still follows the full WAIT/RESP timing.
//   Stores do not modify the array. rsp_rdata=0, rsp_err=1.
//   Aligned accesses return rsp_err=0.
//  MEM_MISALIGN_TRAP_EN undefined: rsp_err tied 0; misaligned accesses are aligned down
//   as in BEHAVIOUR.
// STRUCTURE
//  Shared package/include mem_defs:
//   size codes SZ_BYTE/SZ_HALF/SZ_WORD
//   state encodings ST_IDLE/ST_WAIT/ST_RESP
//   function for the lane mask from size and addr[1:0]
//  One sub-module, mem_lane_align (combinational):
//   store path: wdata replication plus byte mask
//   load path: lane extract plus sign/zero extend
//   misalignment detect output
//  Top level holds the FSM, wait counter, latched request and storage array.
// TESTING
//  1. WAIT_STATES=2: store word 0xDEADBEEF @0x10, then load word @0x10
//     -> rsp_valid 3 cycles after each accept; rdata=0xDEADBEEF.
//  2. Store byte 0x80 @0x13, then load byte signed @0x13 -> 0xFFFFFF80;
//     load byte unsigned @0x13 -> 0x00000080; load word @0x10 -> 0x80ADBEEF.
//  3. Store half 0x1234 @0x22; load half signed @0x22 -> 0x00001234;
//     word @0x20 has [15:0] unchanged from its prior value.
//  4. Backpressure: hold rsp_ready=0 for 5 cycles
//     -> rsp_valid and rdata stable, req_ready=0 throughout;
//     after the handshake, the next req is accepted one cycle later.
//  5. Address wrap, DEPTH=1024: store 0xA5A5A5A5 @0x1000
//     -> load @0x0000 returns 0xA5A5A5A5.
//  6. Assert rst_n=0 during WAIT of a store @0x40 (prior 0x0)
//     -> rsp_valid=0 immediately; later load @0x40 returns 0x0.
//     With MEM_MISALIGN_TRAP_EN: word load @0x41 -> rsp_err=1, rdata=0;
//     without the macro it returns the word @0x40.

Source files
------------

// File: rtl/unified_mem_responder_pkg.sv
// Shared memory definitions for the unified memory responder: size codes,
// FSM state encodings and the byte-lane mask helper.
`timescale 1ns/1ps
package unified_mem_responder_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE     = 2'b00,
        SZ_HALF     = 2'b01,
        SZ_WORD     = 2'b10,
        SZ_WORD_ALT = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Byte enables for an access; misaligned halves/words are aligned down.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] mask;
        case (size)
            SZ_BYTE: mask = 4'b0001 << addr_lo;
            SZ_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/unified_mem_responder_if.sv
// Request/response bus between the datapath address mux and the memory responder.
`timescale 1ns/1ps
interface unified_mem_responder_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/unified_mem_responder_lane_align.sv
// mem_lane_align: combinational byte-lane steering for the memory responder.
// Store path replicates write data across lanes and builds the byte mask;
// load path extracts the addressed lane and sign/zero extends it.
`timescale 1ns/1ps
module mem_lane_align
    import unified_mem_responder_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] wdata_rep,
    output logic [3:0]  byte_mask,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [1:0]  offset;
    logic [31:0] shifted;

    // Steer store data, extract load lane and flag misalignment.
    always_comb begin
        wdata_rep  = wdata;
        byte_mask  = lane_mask(size, addr_lo);
        rdata_ext  = rword;
        misaligned = 1'b0;
        offset     = 2'b00;
        case (size)
            SZ_BYTE: begin
                offset    = addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                offset     = {addr_lo[1], 1'b0};
                wdata_rep  = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
            end
            default: begin
                misaligned = (addr_lo != 2'b00);
            end
        endcase
        shifted = rword >> {offset, 3'b000};
        case (size)
            SZ_BYTE: rdata_ext = is_unsigned ? {24'h0, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: rdata_ext = is_unsigned ? {16'h0, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
            default: rdata_ext = rword;
        endcase
    end

endmodule

// File: rtl/unified_mem_responder.sv
// unified_mem_responder: memory-side responder for the unified address path.
// Accepts one load/store, waits WAIT_STATES cycles, commits to the word array
// and holds the response until consumed.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned accesses report
// rsp_err and leave the array untouched instead of being aligned down).
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | req_ready high, waiting for a request
// ST_WAIT | wait-state down-counter running, request latched
// ST_RESP | response held on rsp_* until rsp_ready
`timescale 1ns/1ps
module unified_mem_responder
    import unified_mem_responder_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    unified_mem_responder_if.slave bus
);

    localparam int         IDX_W = $clog2(DEPTH);
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    state_e             state, state_next;
    logic [3:0]         cnt, cnt_next;
    logic               ready_q;
    logic               accept;
    logic               commit;
    logic               in_idle;

    logic               we_q;
    logic [1:0]         size_q;
    logic               uns_q;
    logic [IDX_W-1:0]   idx_q;
    logic [1:0]         lo_q;
    logic [31:0]        wdata_q;

    logic               cur_we;
    logic [1:0]         cur_size;
    logic               cur_uns;
    logic [IDX_W-1:0]   cur_idx;
    logic [1:0]         cur_lo;
    logic [31:0]        cur_wdata;

    logic [31:0]        mem [DEPTH];
    logic [31:0]        rword;
    logic [31:0]        wdata_rep;
    logic [3:0]         byte_mask;
    logic [31:0]        rdata_ext;
    logic               misaligned;
    logic               trap;
    logic [31:0]        rdata_q;
    logic               unused_addr_hi;

    assign unused_addr_hi = ^bus.req_addr[ADDR_W-1:IDX_W+2];

    // With zero wait states the commit happens on the accept edge, so the live
    // request fields are used in IDLE and the latched copy otherwise.
    assign in_idle   = (state == ST_IDLE);
    assign cur_we    = in_idle ? bus.req_we                : we_q;
    assign cur_size  = in_idle ? bus.req_size              : size_q;
    assign cur_uns   = in_idle ? bus.req_unsigned          : uns_q;
    assign cur_idx   = in_idle ? bus.req_addr[IDX_W+1:2]   : idx_q;
    assign cur_lo    = in_idle ? bus.req_addr[1:0]         : lo_q;
    assign cur_wdata = in_idle ? bus.req_wdata             : wdata_q;
    assign rword     = mem[cur_idx];

    mem_lane_align u_lane_align (
        .size        (cur_size),
        .addr_lo     (cur_lo),
        .is_unsigned (cur_uns),
        .wdata       (cur_wdata),
        .rword       (rword),
        .wdata_rep   (wdata_rep),
        .byte_mask   (byte_mask),
        .rdata_ext   (rdata_ext),
        .misaligned  (misaligned)
    );

`ifdef MEM_MISALIGN_TRAP_EN
    logic err_q;
    assign trap = misaligned;

    // Error flag captured at commit and held with the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      err_q <= 1'b0;
        else if (commit) err_q <= trap;
    end

    assign bus.rsp_err = err_q;
`else
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
    assign trap              = 1'b0;
    assign bus.rsp_err       = 1'b0;
`endif

    assign accept        = in_idle && ready_q && bus.req_valid;
    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_rdata = rdata_q;

    // Next-state and wait-counter logic; commit marks the transition into RESP.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        commit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (WS == 4'd0) begin
                        state_next = ST_RESP;
                        commit     = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = WS;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd1) begin
                    state_next = ST_RESP;
                    cnt_next   = 4'd0;
                    commit     = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, counter and registered ready (low through reset, high in IDLE).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            ready_q <= (state_next == ST_IDLE);
        end
    end

    // Request fields latched on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            idx_q   <= '0;
            lo_q    <= 2'b00;
            wdata_q <= 32'h0;
        end else if (accept) begin
            we_q    <= bus.req_we;
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            idx_q   <= bus.req_addr[IDX_W+1:2];
            lo_q    <= bus.req_addr[1:0];
            wdata_q <= bus.req_wdata;
        end
    end

    // Response data captured at commit; stores and trapped accesses return 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      rdata_q <= 32'h0;
        else if (commit) rdata_q <= (cur_we || trap) ? 32'h0 : rdata_ext;
    end

    // Storage array, byte-masked write at commit; contents are not reset.
    always_ff @(posedge clk) begin
        if (commit && cur_we && !trap) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_mask[b]) mem[cur_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_unified_mem_responder.sv
// Directed bench for unified_mem_responder (WAIT_STATES=2, DEPTH=1024).
`timescale 1ns/1ps
module tb_unified_mem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    unified_mem_responder_if #(.ADDR_W(32)) bus ();

    unified_mem_responder #(
        .ADDR_W      (32),
        .DEPTH       (1024),
        .WAIT_STATES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    // One full transaction starting at a negedge; ends at the negedge after the
    // response handshake.
    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wd,
                        input int hold, output logic [31:0] rd, output logic err);
        int waits = 0;
        int lat   = 0;
        bus.req_we       = we;
        bus.req_addr     = addr;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_wdata    = wd;
        bus.req_valid    = 1'b1;
        while (!bus.req_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        chk({tag, ".acc_wait"}, 32'(waits), 32'd0);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rsp_valid && lat < 20);
        chk({tag, ".latency"}, 32'(lat), 32'd3);
        rd  = bus.rsp_rdata;
        err = bus.rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, ".hold_valid"}, 32'(bus.rsp_valid), 32'd1);
            chk({tag, ".hold_rdata"}, bus.rsp_rdata, rd);
            chk({tag, ".hold_ready"}, 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk({tag, ".post_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, ".post_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    task automatic store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] wd, input logic exp_err);
        logic [31:0] rd;
        logic        err;
        xact(tag, 1'b1, addr, size, 1'b0, wd, 0, rd, err);
        chk({tag, ".rdata"}, rd, 32'h0);
        chk({tag, ".err"}, 32'(err), 32'(exp_err));
    endtask

    task automatic load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] exp, input logic exp_err,
                        input int hold);
        logic [31:0] rd;
        logic        err;
        xact(tag, 1'b0, addr, size, uns, 32'h0, hold, rd, err);
        chk({tag, ".rdata"}, rd, exp);
        chk({tag, ".err"}, 32'(err), 32'(exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waits;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_wdata    = 32'h0;
        bus.rsp_ready    = 1'b0;

        // Reset values
        #2;
        chk("rst.req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst.rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst.rsp_err",   32'(bus.rsp_err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.ready_rise", 32'(bus.req_ready), 32'd1);

        // 1: word store/load
        store("t1_st", 32'h10, 2'b10, 32'hDEADBEEF, 1'b0);
        load ("t1_ld", 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 0);

        // 2: byte lanes
        store("t2_st",   32'h13, 2'b00, 32'h00000080, 1'b0);
        load ("t2_sb13", 32'h13, 2'b00, 1'b0, 32'hFFFFFF80, 1'b0, 0);
        load ("t2_ub13", 32'h13, 2'b00, 1'b1, 32'h00000080, 1'b0, 0);
        load ("t2_w10",  32'h10, 2'b10, 1'b0, 32'h80ADBEEF, 1'b0, 0);
        load ("t2_ub11", 32'h11, 2'b00, 1'b1, 32'h000000BE, 1'b0, 0);
        load ("t2_sb12", 32'h12, 2'b00, 1'b0, 32'hFFFFFFAD, 1'b0, 0);

        // 3: half lanes
        store("t3_w20",  32'h20, 2'b10, 32'hCAFEF00D, 1'b0);
        store("t3_h22",  32'h22, 2'b01, 32'h00001234, 1'b0);
        load ("t3_sh22", 32'h22, 2'b01, 1'b0, 32'h00001234, 1'b0, 0);
        load ("t3_w20b", 32'h20, 2'b10, 1'b0, 32'h1234F00D, 1'b0, 0);
        store("t3_h20",  32'h20, 2'b01, 32'h0000BEEF, 1'b0);
        load ("t3_sh20", 32'h20, 2'b01, 1'b0, 32'hFFFFBEEF, 1'b0, 0);
        load ("t3_uh20", 32'h20, 2'b01, 1'b1, 32'h0000BEEF, 1'b0, 0);

        // 4: backpressure then immediate next request
        load ("t4_bp",   32'h10, 2'b10, 1'b0, 32'h80ADBEEF, 1'b0, 5);
        load ("t4_next", 32'h20, 2'b10, 1'b0, 32'h1234BEEF, 1'b0, 0);

        // 5: address wrap
        store("t5_w40",  32'h40,   2'b10, 32'h00000000, 1'b0);
        store("t5_st",   32'h1000, 2'b10, 32'hA5A5A5A5, 1'b0);
        load ("t5_ld0",  32'h0,    2'b10, 1'b0, 32'hA5A5A5A5, 1'b0, 0);
        load ("t5_ld1",  32'h1010, 2'b10, 1'b0, 32'h80ADBEEF, 1'b0, 0);

        // 6: reset during WAIT of a store drops it
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h40;
        bus.req_size  = 2'b10;
        bus.req_wdata = 32'h12345678;
        bus.req_valid = 1'b1;
        waits = 0;
        while (!bus.req_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        chk("t6.acc_wait", 32'(waits), 32'd0);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6.rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("t6.rst_ready", 32'(bus.req_ready), 32'd0);
        chk("t6.rst_rdata", bus.rsp_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6.ready_back", 32'(bus.req_ready), 32'd1);
        repeat (3) @(negedge clk);
        chk("t6.no_rsp", 32'(bus.rsp_valid), 32'd0);
        load("t6_ld40", 32'h40, 2'b10, 1'b0, 32'h00000000, 1'b0, 0);

        // Misaligned accesses
`ifdef MEM_MISALIGN_TRAP_EN
        load ("mis_w41", 32'h41, 2'b10, 1'b0, 32'h00000000, 1'b1, 0);
        store("mis_s42", 32'h42, 2'b10, 32'hDDDDDDDD, 1'b1);
        load ("mis_chk", 32'h40, 2'b10, 1'b0, 32'h00000000, 1'b0, 0);
        load ("mis_h23", 32'h23, 2'b01, 1'b1, 32'h00000000, 1'b1, 0);
`else
        load ("mis_w11", 32'h11, 2'b10, 1'b0, 32'h80ADBEEF, 1'b0, 0);
        load ("mis_h23", 32'h23, 2'b01, 1'b1, 32'h00001234, 1'b0, 0);
        store("mis_s21", 32'h21, 2'b01, 32'h00005678, 1'b0);
        load ("mis_chk", 32'h20, 2'b10, 1'b0, 32'h12345678, 1'b0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
